watch_mode_ctrl: RTL and testbench
==================================

Name: watch_mode_ctrl

Overview:
- Central mode and key-event scheduler for the watch/stopwatch display board.
- Takes debounced key events from the two key_process instances and runs a single mode state machine. The modes are normal watch, hour setting, minute setting and stopwatch.
- Routes each key event to exactly one consumer as a one-cycle command strobe (hour/minute increment, stopwatch start/stop/clear).
- Drives the display-select, field-select, blink and indicator signals consumed by display_hex.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- BLINK_HZ, 1: blink frequency; blink toggles every CLK_HZ/(2*BLINK_HZ) cycles.
- TIMEOUT_S, 10: inactivity time in seconds before a setting state auto-exits to WATCH.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- key_first_1  in  1  one-cycle short-press pulse, key 1.
- key_long_1  in  1  one-cycle long-press pulse, key 1.
- key_first_2  in  1  one-cycle short-press pulse, key 2.
- key_long_2  in  1  one-cycle long-press pulse, key 2.
- dsp_hex  out  1  display source: 1 = watch digits, 0 = stopwatch digits.
- set_active  out  1  high in SET_HOUR/SET_MIN; drives led_setting.
- sel_field  out  2  field being edited: 0 = none, 1 = minutes (Hex_0/1), 2 = hours (Hex_2/3).
- blink  out  1  blink phase; 0 = blank the selected field.
- led_point  out  1  colon/point indicator.
- inc_hour  out  1  one-cycle pulse: hours +1 (wrap is handled by m_watch).
- inc_min  out  1  one-cycle pulse: minutes +1.
- sw_start_stop  out  1  one-cycle pulse: toggle stopwatch run.
- sw_clear  out  1  one-cycle pulse: clear stopwatch.
- sw_running  out  1  controller's record of stopwatch run state.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state WATCH, dsp_hex=1, set_active=0, sel_field=0, blink=1, led_point=1;
  - all pulses 0, sw_running=0, blink and timeout counters 0.
- Outputs are registered. Command pulses assert exactly one cycle, the cycle after the input event is sampled.
- Event arbitration (per cycle):
  - Long beats short on the same key.
  - A key-1 event beats a key-2 event arriving in the same cycle; the losing event is dropped, not queued.
- States and transitions:
  - WATCH:
    - key_long_1 -> STOPWATCH.
    - key_long_2 -> SET_HOUR.
    - Short presses are ignored.
  - SET_HOUR:
    - key_first_2 -> inc_hour pulse, stay.
    - key_first_1 -> SET_MIN.
    - key_long_2 or timeout -> WATCH.
    - key_long_1 is ignored.
  - SET_MIN:
    - key_first_2 -> inc_min pulse, stay.
    - key_first_1, key_long_2 or timeout -> WATCH.
    - key_long_1 is ignored.
  - STOPWATCH:
    - key_long_1 -> WATCH.
    - key_first_1 -> sw_start_stop pulse and toggle sw_running.
    - key_first_2 -> sw_clear pulse only if sw_running=0; ignored while running.
    - key_long_2 is ignored.
- Output decode per state:
  - dsp_hex = 0 only in STOPWATCH.
  - sel_field = 2 in SET_HOUR, 1 in SET_MIN, 0 elsewhere.
  - led_point = blink in WATCH, 1 in SET_*, sw_running in STOPWATCH.
- sw_running persists across mode changes; the stopwatch keeps counting in the background while in WATCH or SET_*.
- Blink counter:
  - Free-running, width $clog2(CLK_HZ/(2*BLINK_HZ)).
  - At terminal count it wraps to 0 and toggles blink.
  - On entry to SET_HOUR or SET_MIN, and on every inc_* pulse, the counter is reset to 0 and blink is forced to 1, so an edited field is visible immediately.
- Timeout counter:
  - Active only in SET_*; width $clog2(TIMEOUT_S*CLK_HZ+1).
  - Cleared on state entry and on any accepted or ignored key event.
  - Reaching TIMEOUT_S*CLK_HZ forces WATCH in the next cycle. Held at 0 outside SET_*.
- No setting-state edit is committed by this block. Increments take effect in m_watch immediately, so timeout and exit paths are equivalent.
- Reset mid-operation:
  - Any pulse in flight is cancelled.
  - sw_running returns to 0, so the stopwatch must also be reset by the same rst_n.
- Terminal counts are computed at elaboration. CLK_HZ < 2*BLINK_HZ is illegal; a simulation assertion fails on it.

Test Plan:
(All scenarios use CLK_HZ=20, BLINK_HZ=1, TIMEOUT_S=2: blink toggles every 10 cycles, timeout is 40 cycles.)
- Reset, then idle 25 cycles:
  - dsp_hex=1, sel_field=0, no pulses.
  - blink and led_point toggle at cycles 10 and 20.
- Set time:
  - Stimulus: key_long_2; key_first_2 x3 (spaced 5 cycles); key_first_1; key_first_2 x2; key_first_1.
  - Required: sel_field 2 -> 1 -> 0, three inc_hour pulses then two inc_min pulses, final state WATCH with set_active=0.
  - blink=1 in the cycle after each inc pulse.
- Timeout: key_long_2 then no keys.
  - set_active=1 for 40 cycles, WATCH on cycle 41.
  - A key_first_2 at cycle 30 delays the exit to cycle 71.
- Stopwatch:
  - Stimulus: key_long_1; key_first_1; key_first_2; key_first_1; key_first_2.
  - Required: dsp_hex=0, sw_start_stop x2, sw_running 1 then 0; the first key_first_2 gives no sw_clear, the second gives one sw_clear.
  - key_long_1 then returns dsp_hex=1 with sw_running preserved.
- Simultaneous events in WATCH:
  - key_long_1 with key_long_2 in the same cycle -> STOPWATCH only.
  - key_first_1 with key_long_1 -> long wins.
- Async reset asserted mid-SET_MIN, in the same cycle as key_first_2:
  - All outputs return to reset values within that cycle, no inc_min is emitted, state is WATCH after release.

Source files
------------

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: mode state machine and key-event router for the watch/stopwatch board.
// Turns debounced key pulses into one-cycle command strobes and drives the display-select,
// field-select, blink and indicator signals used by display_hex.
module watch_mode_ctrl #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BLINK_HZ  = 1,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_first_1,
  input  logic       key_long_1,
  input  logic       key_first_2,
  input  logic       key_long_2,
  output logic       dsp_hex,
  output logic       set_active,
  output logic [1:0] sel_field,
  output logic       blink,
  output logic       led_point,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       sw_start_stop,
  output logic       sw_clear,
  output logic       sw_running
);

  // Cycles per blink half-period and per inactivity timeout.
  localparam int unsigned BLINK_TC = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned BLINK_W  = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;
  localparam int unsigned TO_TC    = TIMEOUT_S * CLK_HZ;
  localparam int unsigned TO_W     = (TO_TC > 0) ? $clog2(TO_TC + 1) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TC - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TO_TC);

  // A blink period shorter than two clocks cannot be produced.
  if (CLK_HZ < 2 * BLINK_HZ) begin : g_bad_blink_cfg
    $fatal(1, "watch_mode_ctrl: CLK_HZ must be at least 2*BLINK_HZ");
  end

  typedef enum logic [1:0] {
    ST_WATCH     = 2'd0,
    ST_SET_HOUR  = 2'd1,
    ST_SET_MIN   = 2'd2,
    ST_STOPWATCH = 2'd3
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic [TO_W-1:0]    to_cnt_q;
  logic [TO_W-1:0]    to_cnt_d;

  logic ev_long_1;
  logic ev_short_1;
  logic ev_long_2;
  logic ev_short_2;
  logic any_key;
  logic timeout;

  logic       in_set_d;
  logic       enter_set;
  logic       blink_restart;
  logic       blink_d;
  logic       dsp_hex_d;
  logic [1:0] sel_field_d;
  logic       led_point_d;
  logic       inc_hour_d;
  logic       inc_min_d;
  logic       sw_start_stop_d;
  logic       sw_clear_d;
  logic       sw_running_d;

  // Per-cycle arbitration: long beats short on a key, key 1 beats key 2; losers are dropped.
  always_comb begin
    ev_long_1  = key_long_1;
    ev_short_1 = key_first_1 & ~key_long_1;
    ev_long_2  = key_long_2 & ~(key_first_1 | key_long_1);
    ev_short_2 = key_first_2 & ~key_long_2 & ~(key_first_1 | key_long_1);
    any_key    = key_first_1 | key_long_1 | key_first_2 | key_long_2;
    timeout    = (to_cnt_q == TO_LAST);
  end

  // Next mode and command strobes; an expired timeout takes precedence over any key.
  always_comb begin
    state_d         = state_q;
    inc_hour_d      = 1'b0;
    inc_min_d       = 1'b0;
    sw_start_stop_d = 1'b0;
    sw_clear_d      = 1'b0;
    sw_running_d    = sw_running;
    case (state_q)
      ST_WATCH: begin
        if (ev_long_1) begin
          state_d = ST_STOPWATCH;
        end else if (ev_long_2) begin
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        if (timeout) begin
          state_d = ST_WATCH;
        end else if (ev_short_2) begin
          inc_hour_d = 1'b1;
        end else if (ev_short_1) begin
          state_d = ST_SET_MIN;
        end else if (ev_long_2) begin
          state_d = ST_WATCH;
        end
      end
      ST_SET_MIN: begin
        if (timeout) begin
          state_d = ST_WATCH;
        end else if (ev_short_2) begin
          inc_min_d = 1'b1;
        end else if (ev_short_1 || ev_long_2) begin
          state_d = ST_WATCH;
        end
      end
      ST_STOPWATCH: begin
        if (ev_long_1) begin
          state_d = ST_WATCH;
        end else if (ev_short_1) begin
          sw_start_stop_d = 1'b1;
          sw_running_d    = ~sw_running;
        end else if (ev_short_2 && !sw_running) begin
          sw_clear_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_WATCH;
      end
    endcase
  end

  // Blink and timeout counters plus the per-mode output decode of the next state.
  always_comb begin
    in_set_d      = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);
    enter_set     = in_set_d && (state_d != state_q);
    blink_restart = enter_set | inc_hour_d | inc_min_d;
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_d       = blink;
    to_cnt_d      = to_cnt_q + TO_W'(1);
    dsp_hex_d     = 1'b1;
    sel_field_d   = 2'd0;
    led_point_d   = 1'b1;

    // Restart the phase so an edited field shows at once.
    if (blink_restart) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink;
    end

    if (!in_set_d || enter_set || any_key) begin
      to_cnt_d = '0;
    end

    case (state_d)
      ST_WATCH: begin
        led_point_d = blink_d;
      end
      ST_SET_HOUR: begin
        sel_field_d = 2'd2;
      end
      ST_SET_MIN: begin
        sel_field_d = 2'd1;
      end
      ST_STOPWATCH: begin
        dsp_hex_d   = 1'b0;
        led_point_d = sw_running_d;
      end
      default: begin
        dsp_hex_d = 1'b1;
      end
    endcase
  end

  // State, counters and all outputs registered; reset cancels any pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WATCH;
      blink_cnt_q   <= '0;
      to_cnt_q      <= '0;
      dsp_hex       <= 1'b1;
      set_active    <= 1'b0;
      sel_field     <= 2'd0;
      blink         <= 1'b1;
      led_point     <= 1'b1;
      inc_hour      <= 1'b0;
      inc_min       <= 1'b0;
      sw_start_stop <= 1'b0;
      sw_clear      <= 1'b0;
      sw_running    <= 1'b0;
    end else begin
      state_q       <= state_d;
      blink_cnt_q   <= blink_cnt_d;
      to_cnt_q      <= to_cnt_d;
      dsp_hex       <= dsp_hex_d;
      set_active    <= in_set_d;
      sel_field     <= sel_field_d;
      blink         <= blink_d;
      led_point     <= led_point_d;
      inc_hour      <= inc_hour_d;
      inc_min       <= inc_min_d;
      sw_start_stop <= sw_start_stop_d;
      sw_clear      <= sw_clear_d;
      sw_running    <= sw_running_d;
    end
  end

  // At most one consumer receives a command in any cycle.
  a_pulse_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({inc_hour, inc_min, sw_start_stop, sw_clear}));

  // Field select never takes the unused encoding.
  a_sel_field_legal: assert property (@(posedge clk) disable iff (!rst_n)
    sel_field != 2'd3);

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: directed scenarios plus randomized key traffic against a behavioural model.
module tb_watch_mode_ctrl;

  localparam int unsigned CLK_HZ    = 20;
  localparam int unsigned BLINK_HZ  = 1;
  localparam int unsigned TIMEOUT_S = 2;
  localparam int BLINK_HALF  = 10;
  localparam int TIMEOUT_CYC = 40;

  localparam int M_WATCH = 0;
  localparam int M_HOUR  = 1;
  localparam int M_MIN   = 2;
  localparam int M_SW    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_first_1 = 1'b0;
  logic       key_long_1 = 1'b0;
  logic       key_first_2 = 1'b0;
  logic       key_long_2 = 1'b0;
  logic       dsp_hex;
  logic       set_active;
  logic [1:0] sel_field;
  logic       blink;
  logic       led_point;
  logic       inc_hour;
  logic       inc_min;
  logic       sw_start_stop;
  logic       sw_clear;
  logic       sw_running;

  watch_mode_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .BLINK_HZ  (BLINK_HZ),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_first_1   (key_first_1),
    .key_long_1    (key_long_1),
    .key_first_2   (key_first_2),
    .key_long_2    (key_long_2),
    .dsp_hex       (dsp_hex),
    .set_active    (set_active),
    .sel_field     (sel_field),
    .blink         (blink),
    .led_point     (led_point),
    .inc_hour      (inc_hour),
    .inc_min       (inc_min),
    .sw_start_stop (sw_start_stop),
    .sw_clear      (sw_clear),
    .sw_running    (sw_running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observed pulse tallies for the directed scenarios.
  int n_ih = 0;
  int n_im = 0;
  int n_ss = 0;
  int n_clr = 0;

  // Behavioural model: mode number, run flag, cycles since the blink phase was
  // anchored, cycles of inactivity in a setting mode, and this cycle's commands.
  int m_mode;
  bit m_run;
  int m_blink_age;
  int m_idle;
  bit m_ih, m_im, m_ss, m_clr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_WATCH;
    m_run       = 1'b0;
    m_blink_age = 0;
    m_idle      = 0;
    m_ih = 1'b0; m_im = 1'b0; m_ss = 1'b0; m_clr = 1'b0;
  endtask

  function automatic bit in_set(input int mode);
    return (mode == M_HOUR) || (mode == M_MIN);
  endfunction

  task automatic model_step(input bit k1f, input bit k1l, input bit k2f, input bit k2l);
    int ev;
    int prev;
    bit any;
    bit edit;
    any = k1f | k1l | k2f | k2l;
    // 1 long1, 2 short1, 3 long2, 4 short2, 0 none
    if (k1l)      ev = 1;
    else if (k1f) ev = 2;
    else if (k2l) ev = 3;
    else if (k2f) ev = 4;
    else          ev = 0;
    prev = m_mode;
    m_ih = 1'b0; m_im = 1'b0; m_ss = 1'b0; m_clr = 1'b0;
    if (in_set(m_mode) && m_idle >= TIMEOUT_CYC) begin
      m_mode = M_WATCH;
    end else begin
      case (m_mode)
        M_WATCH: begin
          if (ev == 1) m_mode = M_SW;
          else if (ev == 3) m_mode = M_HOUR;
        end
        M_HOUR: begin
          if (ev == 4) m_ih = 1'b1;
          else if (ev == 2) m_mode = M_MIN;
          else if (ev == 3) m_mode = M_WATCH;
        end
        M_MIN: begin
          if (ev == 4) m_im = 1'b1;
          else if (ev == 2 || ev == 3) m_mode = M_WATCH;
        end
        default: begin
          if (ev == 1) m_mode = M_WATCH;
          else if (ev == 2) begin m_ss = 1'b1; m_run = !m_run; end
          else if (ev == 4 && !m_run) m_clr = 1'b1;
        end
      endcase
    end
    edit = (in_set(m_mode) && m_mode != prev) || m_ih || m_im;
    m_blink_age = edit ? 0 : m_blink_age + 1;
    m_idle = (in_set(m_mode) && m_mode == prev && !any) ? m_idle + 1 : 0;
  endtask

  task automatic compare_all();
    bit eb;
    bit el;
    int es;
    eb = ((m_blink_age / BLINK_HALF) % 2) == 0;
    el = (m_mode == M_WATCH) ? eb : ((m_mode == M_SW) ? m_run : 1'b1);
    es = (m_mode == M_HOUR) ? 2 : ((m_mode == M_MIN) ? 1 : 0);
    check("dsp_hex",       32'(dsp_hex),       32'(m_mode != M_SW));
    check("set_active",    32'(set_active),    32'(in_set(m_mode)));
    check("sel_field",     32'(sel_field),     32'(es));
    check("blink",         32'(blink),         32'(eb));
    check("led_point",     32'(led_point),     32'(el));
    check("inc_hour",      32'(inc_hour),      32'(m_ih));
    check("inc_min",       32'(inc_min),       32'(m_im));
    check("sw_start_stop", 32'(sw_start_stop), 32'(m_ss));
    check("sw_clear",      32'(sw_clear),      32'(m_clr));
    check("sw_running",    32'(sw_running),    32'(m_run));
    n_ih  += int'(inc_hour);
    n_im  += int'(inc_min);
    n_ss  += int'(sw_start_stop);
    n_clr += int'(sw_clear);
  endtask

  // Called just after a falling edge: present keys for one cycle, then check after the next fall.
  task automatic step(input bit k1f, input bit k1l, input bit k2f, input bit k2l);
    key_first_1 = k1f;
    key_long_1  = k1l;
    key_first_2 = k2f;
    key_long_2  = k2l;
    @(posedge clk);
    model_step(k1f, k1l, k2f, k2l);
    @(negedge clk);
    key_first_1 = 1'b0;
    key_long_1  = 1'b0;
    key_first_2 = 1'b0;
    key_long_2  = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dsp_hex"},    32'(dsp_hex),    32'd1);
    check({tag, "_set_active"}, 32'(set_active), 32'd0);
    check({tag, "_sel_field"},  32'(sel_field),  32'd0);
    check({tag, "_blink"},      32'(blink),      32'd1);
    check({tag, "_led_point"},  32'(led_point),  32'd1);
    check({tag, "_pulses"},     32'({inc_hour, inc_min, sw_start_stop, sw_clear}), 32'd0);
    check({tag, "_sw_running"}, 32'(sw_running), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_tallies();
    n_ih = 0; n_im = 0; n_ss = 0; n_clr = 0;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Idle after reset: blink and point toggle every ten cycles, nothing else moves.
    clear_tallies();
    for (int i = 1; i <= 25; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 9)  check("idle_blink_c9",  32'(blink), 32'd1);
      if (i == 10) check("idle_blink_c10", 32'(blink), 32'd0);
      if (i == 10) check("idle_led_c10",   32'(led_point), 32'd0);
      if (i == 20) check("idle_blink_c20", 32'(blink), 32'd1);
    end
    check("idle_pulses", 32'(n_ih + n_im + n_ss + n_clr), 32'd0);

    // Set time: three hour increments, two minute increments, back to watch.
    clear_tallies();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("set_sel_hour", 32'(sel_field), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("set_blink_after_inc_h", 32'(blink), 32'd1);
      idle(3);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("set_sel_min", 32'(sel_field), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("set_blink_after_inc_m", 32'(blink), 32'd1);
      idle(3);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("set_sel_none", 32'(sel_field), 32'd0);
    check("set_exit_active", 32'(set_active), 32'd0);
    check("set_inc_hour_count", 32'(n_ih), 32'd3);
    check("set_inc_min_count", 32'(n_im), 32'd2);
    idle(3);

    // Timeout: 40 idle cycles in a setting mode, exit on the 41st.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      if (i == TIMEOUT_CYC) check("to_still_active_c40", 32'(set_active), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_exit_c41", 32'(set_active), 32'd0);

    // Timeout restarted by a key at cycle 30: exit moves to cycle 71.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(29);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(TIMEOUT_CYC);
    check("to_late_active_c70", 32'(set_active), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_late_exit_c71", 32'(set_active), 32'd0);
    idle(2);

    // Stopwatch: start, refused clear, stop, accepted clear.
    clear_tallies();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("sw_dsp_hex", 32'(dsp_hex), 32'd0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sw_running_on", 32'(sw_running), 32'd1);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sw_no_clear_running", 32'(sw_clear), 32'd0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sw_running_off", 32'(sw_running), 32'd0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sw_clear_stopped", 32'(sw_clear), 32'd1);
    check("sw_ss_count", 32'(n_ss), 32'd2);
    check("sw_clr_count", 32'(n_clr), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("sw_leave_dsp", 32'(dsp_hex), 32'd1);
    check("sw_leave_keeps_run", 32'(sw_running), 32'd1);
    idle(2);

    // Simultaneous events in WATCH.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("sim_ll_dsp", 32'(dsp_hex), 32'd0);
    check("sim_ll_set", 32'(set_active), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("sim_fl_dsp", 32'(dsp_hex), 32'd0);
    check("sim_fl_no_ss", 32'(sw_start_stop), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Async reset in SET_MIN together with a key_first_2.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_sel_min", 32'(sel_field), 32'd1);
    key_first_2 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk);
    #1;
    check("mid_rst_no_inc_min", 32'(inc_min), 32'd0);
    @(negedge clk);
    key_first_2 = 1'b0;
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_after_dsp", 32'(dsp_hex), 32'd1);
    check("mid_after_sel", 32'(sel_field), 32'd0);
    check("mid_after_set", 32'(set_active), 32'd0);

    // Randomized traffic, alternating dense and sparse phases, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit dense;
      bit k1f, k1l, k2f, k2l;
      dense = ((i / 300) % 2) == 0;
      if (dense) begin
        k1f = ($urandom_range(0, 9) == 0);
        k1l = ($urandom_range(0, 14) == 0);
        k2f = ($urandom_range(0, 7) == 0);
        k2l = ($urandom_range(0, 14) == 0);
      end else begin
        k1f = ($urandom_range(0, 149) == 0);
        k1l = ($urandom_range(0, 199) == 0);
        k2f = ($urandom_range(0, 99) == 0);
        k2l = ($urandom_range(0, 119) == 0);
      end
      if ($urandom_range(0, 999) == 0) apply_reset();
      else step(k1f, k1l, k2f, k2l);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
